// File: rtl/cv32e41p_pkg.sv
// Shared types for the instruction-fetch front end.
//   fetch_state_e : fetch FSM states
//   fetch_entry_t : one buffered response {rdata, addr, err}
//   word_align()  : clears the byte-offset bits of an address
package cv32e41p_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'b00,
    FETCH_RUN     = 2'b01,
    FETCH_BR_WAIT = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } fetch_entry_t;

  localparam logic [31:0] WORD_INC = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/cv32e41p_fetch_fifo.sv
// Generic response FIFO for the fetch unit.
//   clk, rst      : clock, synchronous active-high reset
//   flush_i       : synchronous flush, overrides push and pop
//   push_i/data_i : write one entry (ignored when full without pop)
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : head entry, all-zero while empty
//   level_o       : occupancy, full_o / empty_o status
module cv32e41p_fetch_fifo
  import cv32e41p_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_C = LVL_W'(DEPTH);

  fetch_entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [LVL_W-1:0]       count_r;
  logic                   push_ok_s;
  logic                   pop_ok_s;

  assign empty_o   = (count_r == {LVL_W{1'b0}});
  assign full_o    = (count_r == DEPTH_C);
  assign level_o   = count_r;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_ok_s);

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      count_r <= count_r + LVL_W'(push_ok_s) - LVL_W'(pop_ok_s);
    end
  end

  // Entry storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush_i) mem_r[wr_ptr_r] <= data_i;
  end

  // Head is forced to zero while empty so outputs are clean after reset/flush.
  always_comb begin
    head_o = '{rdata: 32'h0, addr: 32'h0, err: 1'b0};
    if (empty_o) head_o = '{rdata: 32'h0, addr: 32'h0, err: 1'b0};
    else         head_o = mem_r[rd_ptr_r];
  end

endmodule

// File: rtl/cv32e41p_fetch_unit.sv
// Instruction-fetch front end: issues OBI reads, tracks outstanding
// transactions, buffers responses and redirects on branch.
//   req_i, branch_i, branch_addr_i          : controller interface
//   fetch_valid_o/ready_i/rdata/addr/err    : aligner-side FIFO head
//   instr_req/addr/gnt/rvalid/rdata/err     : OBI instruction bus
//   busy_o, fifo_level_o                    : status
module cv32e41p_fetch_unit
  import cv32e41p_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STOP_ON_ERR     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  input  logic                    branch_i,
  input  logic [31:0]             branch_addr_i,
  output logic                    fetch_valid_o,
  input  logic                    fetch_ready_i,
  output logic [31:0]             fetch_rdata_o,
  output logic [31:0]             fetch_addr_o,
  output logic                    fetch_err_o,
  output logic                    instr_req_o,
  output logic [31:0]             instr_addr_o,
  input  logic                    instr_gnt_i,
  input  logic                    instr_rvalid_i,
  input  logic [31:0]             instr_rdata_i,
  input  logic                    instr_err_i,
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  fifo_level_o
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = LVL_W + 1;
  localparam logic [LVL_W-1:0] MAX_OUT_C = LVL_W'(MAX_OUTSTANDING);
  localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(DEPTH);
  localparam logic [LVL_W-1:0] CNT_ZERO  = {LVL_W{1'b0}};

  fetch_state_e      state_r;
  logic [31:0]       next_addr_r;    // address of the next (or held) request
  logic [31:0]       br_target_r;    // target latched while a request is held
  logic [31:0]       resp_addr_r;    // address of the next kept response
  logic [LVL_W-1:0]  outstanding_r;
  logic [LVL_W-1:0]  discard_r;
  logic              pending_r;      // request was up without grant last cycle
  logic              err_stop_r;

  logic              credit_s;
  logic              gnt_s;
  logic              drop_s;
  logic              push_s;
  logic              pop_s;
  logic [31:0]       target_s;
  logic [OCC_W-1:0]  occ_s;
  logic [LVL_W-1:0]  outstanding_nxt_s;
  logic [LVL_W-1:0]  discard_dec_s;
  logic [LVL_W-1:0]  fifo_level_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  fetch_entry_t      fifo_head_s;
  fetch_entry_t      push_entry_s;

  assign target_s          = word_align(branch_addr_i);
  assign occ_s             = {1'b0, outstanding_r} + {1'b0, fifo_level_s};
  assign gnt_s             = instr_req_o & instr_gnt_i;
  assign drop_s            = instr_rvalid_i & (discard_r != CNT_ZERO);
  // A kept response arriving with a branch is stale and is dropped as well.
  assign pop_s             = ~fifo_empty_s & fetch_ready_i & ~branch_i;
  assign push_s            = instr_rvalid_i & (discard_r == CNT_ZERO) & ~branch_i
                             & (~fifo_full_s | pop_s);
  assign outstanding_nxt_s = outstanding_r + LVL_W'(gnt_s) - LVL_W'(instr_rvalid_i);
  assign discard_dec_s     = discard_r - LVL_W'(drop_s);
  assign push_entry_s      = '{rdata: instr_rdata_i, addr: resp_addr_r, err: instr_err_i};

  // Issue credit: bounded by outstanding limit and by FIFO space reserved for
  // every granted transaction.
  always_comb begin
    credit_s = 1'b0;
    if (req_i && !err_stop_r && (outstanding_r < MAX_OUT_C) && (occ_s < DEPTH_C))
      credit_s = 1'b1;
    else
      credit_s = 1'b0;
  end

  // A held request stays up until granted, independent of req_i/credit/branch.
  always_comb begin
    instr_req_o = 1'b0;
    if (pending_r)                   instr_req_o = 1'b1;
    else if (state_r == FETCH_RUN)   instr_req_o = credit_s;
    else                             instr_req_o = 1'b0;
  end

  assign instr_addr_o = next_addr_r;
  assign busy_o       = (outstanding_r != CNT_ZERO) | pending_r;

  // Fetch FSM with outstanding/discard accounting and response addressing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= FETCH_IDLE;
      next_addr_r   <= 32'h0;
      br_target_r   <= 32'h0;
      resp_addr_r   <= 32'h0;
      outstanding_r <= CNT_ZERO;
      discard_r     <= CNT_ZERO;
      pending_r     <= 1'b0;
      err_stop_r    <= 1'b0;
    end else begin
      pending_r     <= instr_req_o & ~instr_gnt_i;
      outstanding_r <= outstanding_nxt_s;
      if (branch_i) begin
        // Everything still outstanding after this cycle is stale; a request
        // that is still held joins the discard count when it is granted.
        discard_r   <= outstanding_nxt_s;
        err_stop_r  <= 1'b0;
        resp_addr_r <= target_s;
        if (instr_req_o && !instr_gnt_i) begin
          state_r     <= FETCH_BR_WAIT;
          br_target_r <= target_s;
        end else begin
          state_r     <= FETCH_RUN;
          next_addr_r <= target_s;
        end
      end else begin
        if (push_s) resp_addr_r <= resp_addr_r + WORD_INC;
        if (push_s && instr_err_i && (STOP_ON_ERR != 0)) err_stop_r <= 1'b1;
        case (state_r)
          FETCH_IDLE: begin
            discard_r <= discard_dec_s;
          end
          FETCH_RUN: begin
            discard_r <= discard_dec_s;
            if (gnt_s) next_addr_r <= next_addr_r + WORD_INC;
          end
          FETCH_BR_WAIT: begin
            if (gnt_s) begin
              discard_r   <= discard_dec_s + LVL_W'(1'b1);
              next_addr_r <= br_target_r;
              state_r     <= FETCH_RUN;
            end else begin
              discard_r   <= discard_dec_s;
            end
          end
          default: begin
            state_r   <= FETCH_IDLE;
            discard_r <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  cv32e41p_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (branch_i),
    .push_i  (push_s),
    .data_i  (push_entry_s),
    .pop_i   (pop_s),
    .head_o  (fifo_head_s),
    .level_o (fifo_level_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign fetch_valid_o = ~fifo_empty_s;
  assign fetch_rdata_o = fifo_head_s.rdata;
  assign fetch_addr_o  = fifo_head_s.addr;
  assign fetch_err_o   = fifo_head_s.err;
  assign fifo_level_o  = fifo_level_s;

endmodule

// File: tb/tb_cv32e41p_fetch_unit.sv
module tb_cv32e41p_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_err_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        busy_o;
  logic [2:0]  fifo_level_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOERR = 32'h0000_0001;

  typedef struct { logic [31:0] addr; logic stale; } bus_t;
  typedef struct { logic [31:0] rdata; logic [31:0] addr; logic err; } ent_t;

  bus_t        bus_q[$];     // granted transactions in bus order
  ent_t        exp_q[$];     // scoreboard of expected FIFO contents
  logic [31:0] exp_next;     // expected address of next/held request
  logic        br_wait;
  logic [31:0] br_target;

  cv32e41p_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_err_o    (fetch_err_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o),
    .fifo_level_o   (fifo_level_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample 1ns later, then update the model.
  task automatic step(input logic req, input logic br, input logic [31:0] baddr,
                      input logic gnt, input logic rv, input logic rdy,
                      input logic [31:0] err_addr);
    logic        have_rsp;
    logic [31:0] t;
    bus_t        b;
    ent_t        e;
    @(negedge clk);
    have_rsp       = rv && (bus_q.size() > 0);
    req_i          = req;
    branch_i       = br;
    branch_addr_i  = baddr;
    instr_gnt_i    = gnt;
    instr_rvalid_i = have_rsp;
    instr_rdata_i  = have_rsp ? data_of(bus_q[0].addr) : 32'h0;
    instr_err_i    = have_rsp && (bus_q[0].addr == err_addr);
    fetch_ready_i  = rdy;
    #1;
    check("level", {29'b0, fifo_level_o}, 32'(exp_q.size()));
    check("valid", {31'b0, fetch_valid_o}, {31'b0, (exp_q.size() != 0)});
    if (fetch_valid_o && exp_q.size() > 0) begin
      check("head_rdata", fetch_rdata_o, exp_q[0].rdata);
      check("head_addr",  fetch_addr_o,  exp_q[0].addr);
      check("head_err",   {31'b0, fetch_err_o}, {31'b0, exp_q[0].err});
      if (rdy && !br) void'(exp_q.pop_front());
    end
    if (instr_req_o) check("req_addr", instr_addr_o, exp_next);
    if (have_rsp) begin
      b = bus_q.pop_front();
      if (!b.stale && !br) begin
        e.rdata = data_of(b.addr);
        e.addr  = b.addr;
        e.err   = (b.addr == err_addr);
        exp_q.push_back(e);
      end
    end
    if (instr_req_o && gnt) begin
      b.addr  = exp_next;
      b.stale = br_wait || br;
      bus_q.push_back(b);
      if (br_wait) begin
        exp_next = br_target;
        br_wait  = 1'b0;
      end else begin
        exp_next = exp_next + 32'd4;
      end
    end
    if (br) begin
      for (int i = 0; i < bus_q.size(); i++) begin
        b = bus_q[i];
        b.stale = 1'b1;
        bus_q[i] = b;
      end
      exp_q.delete();
      t = baddr & ~32'd3;
      if (instr_req_o && !gnt) begin
        br_wait   = 1'b1;
        br_target = t;
      end else begin
        br_wait  = 1'b0;
        exp_next = t;
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (bus_q.size() == 0 && exp_q.size() == 0) break;
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, NOERR);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, NOERR);
    check({tag, "_busy"},  {31'b0, busy_o}, 32'h0);
    check({tag, "_valid"}, {31'b0, fetch_valid_o}, 32'h0);
  endtask

  initial begin
    logic        seen;
    int          grants;
    logic [31:0] glog[$];
    logic [31:0] wrap_exp[3];

    rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
    fetch_ready_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    instr_rdata_i = 32'h0; instr_err_i = 1'b0;
    exp_next = 32'h0; br_wait = 1'b0; br_target = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   {31'b0, instr_req_o}, 32'h0);
    check("rst_iaddr", instr_addr_o, 32'h0);
    check("rst_valid", {31'b0, fetch_valid_o}, 32'h0);
    check("rst_rdata", fetch_rdata_o, 32'h0);
    check("rst_faddr", fetch_addr_o, 32'h0);
    check("rst_err",   {31'b0, fetch_err_o}, 32'h0);
    check("rst_busy",  {31'b0, busy_o}, 32'h0);
    check("rst_level", {29'b0, fifo_level_o}, 32'h0);
    rst = 1'b0;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, NOERR);
    check("idle_noreq", {31'b0, instr_req_o}, 32'h0);

    // 1: streaming fetch from 0x80
    step(1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1, NOERR);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, NOERR);
    check("t1_req",  {31'b0, instr_req_o}, 32'h1);
    check("t1_addr", instr_addr_o, 32'h0000_0080);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, NOERR);
    drain("t1");

    // 2: consumer stalled, credit caps issue at DEPTH
    step(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1, 1'b0, NOERR);
    grants = 0;
    repeat (10) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, NOERR);
      if (instr_req_o) grants++;
    end
    check("t2_grants", 32'(grants), 32'd4);
    check("t2_noreq",  {31'b0, instr_req_o}, 32'h0);
    check("t2_full",   {29'b0, fifo_level_o}, 32'd4);
    drain("t2");

    // 3: branch with two outstanding discards both responses
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, NOERR);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, NOERR);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, NOERR);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, NOERR);
    check("t3_cap", {31'b0, instr_req_o}, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0, NOERR);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, NOERR);
      if (fetch_valid_o) begin seen = 1'b1; break; end
    end
    check("t3_seen", {31'b0, seen}, 32'h1);
    check("t3_addr", fetch_addr_o, 32'h0000_0200);
    drain("t3");

    // 4: branch while a request is held without grant
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, NOERR);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, NOERR);
    check("t4_addr0", instr_addr_o, 32'h0000_0040);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, NOERR);
    check("t4_hold", {31'b0, instr_req_o}, 32'h1);
    step(1'b1, 1'b1, 32'h0000_0303, 1'b0, 1'b0, 1'b0, NOERR);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, NOERR);
    check("t4_hold_req",  {31'b0, instr_req_o}, 32'h1);
    check("t4_hold_addr", instr_addr_o, 32'h0000_0040);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, NOERR);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, NOERR);
    check("t4_req",  {31'b0, instr_req_o}, 32'h1);
    check("t4_addr", instr_addr_o, 32'h0000_0300);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, NOERR);
      if (fetch_valid_o) begin seen = 1'b1; break; end
    end
    check("t4_seen",  {31'b0, seen}, 32'h1);
    check("t4_faddr", fetch_addr_o, 32'h0000_0300);
    drain("t4");

    // 5: errored response stops issue until the next branch
    step(1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 32'h10);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h10);
      if (fetch_valid_o) begin seen = 1'b1; break; end
    end
    check("t5_seen", {31'b0, seen}, 32'h1);
    check("t5_addr", fetch_addr_o, 32'h0000_0010);
    check("t5_err",  {31'b0, fetch_err_o}, 32'h1);
    repeat (4) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h10);
      check("t5_stop", {31'b0, instr_req_o}, 32'h0);
    end
    step(1'b1, 1'b1, 32'h0000_0020, 1'b1, 1'b1, 1'b1, 32'h10);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h10);
    check("t5_flush",  {29'b0, fifo_level_o}, 32'h0);
    check("t5_resume", {31'b0, instr_req_o}, 32'h1);
    check("t5_raddr",  instr_addr_o, 32'h0000_0020);
    drain("t5");

    // 6: address wrap at the top of memory
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1, NOERR);
    repeat (6) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, NOERR);
      if (instr_req_o) glog.push_back(instr_addr_o);
    end
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++)
      check("t6_wrap", (i < glog.size()) ? glog[i] : 32'hDEAD_DEAD, wrap_exp[i]);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
